// File: rtl/gnn_aggr_layer.sv
// One GNN layer: for each node, sum neighbour features selected by the adjacency row,
// then project through a weight matrix; one node result is emitted per output handshake.
module gnn_aggr_layer #(
  parameter int N_NODES = 4,
  parameter int F_IN    = 4,
  parameter int F_OUT   = 2,
  parameter int IN_W    = 5,
  parameter int W_W     = 5,
  parameter int ACC_W   = 21,
  parameter int RELU    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NODES*F_IN*IN_W-1:0]  x_flat,
  input  logic [N_NODES*N_NODES-1:0]    adj,
  input  logic [F_IN*F_OUT*W_W-1:0]     w_flat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(N_NODES)-1:0]    out_node,
  output logic [F_OUT*ACC_W-1:0]        out_data,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);
  localparam int AG_W    = IN_W + $clog2(N_NODES);
  localparam int P_W     = AG_W + W_W;
  localparam int NODE_W  = $clog2(N_NODES);
  localparam int CNT_MAX = (N_NODES > F_IN) ? N_NODES : F_IN;
  localparam int CNT_W   = $clog2(CNT_MAX);

  generate
    if (ACC_W < IN_W + $clog2(N_NODES) + W_W + $clog2(F_IN)) begin : g_acc_w_check
      $error("gnn_aggr_layer: ACC_W too narrow for the worst-case accumulation");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a presented result holds stable until it is taken.
  typedef enum logic [1:0] {S_IDLE, S_AGGR, S_MAC, S_EMIT} state_t;

  state_t                          state_q, state_d;
  logic [NODE_W-1:0]               i_q, i_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [N_NODES*F_IN*IN_W-1:0]    x_q, x_d;
  logic [N_NODES*N_NODES-1:0]      adj_q, adj_d;
  logic [F_IN*F_OUT*W_W-1:0]       w_q, w_d;
  logic signed [AG_W-1:0]          aggr_q [F_IN];
  logic signed [AG_W-1:0]          aggr_d [F_IN];
  logic signed [ACC_W-1:0]         acc_q [F_OUT];
  logic signed [ACC_W-1:0]         acc_d [F_OUT];

  logic                            adj_bit;
  logic signed [IN_W-1:0]          x_sel [F_IN];
  logic signed [AG_W-1:0]          agg_sel;
  logic signed [W_W-1:0]           w_sel [F_OUT];
  logic signed [P_W-1:0]           prod [F_OUT];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    adj_d   = adj_q;
    w_d     = w_q;
    aggr_d  = aggr_q;
    acc_d   = acc_q;
    adj_bit = 1'b0;
    agg_sel = '0;
    for (int k = 0; k < F_IN; k++) x_sel[k] = '0;
    for (int o = 0; o < F_OUT; o++) begin
      w_sel[o] = '0;
      prod[o]  = '0;
    end

    // The shared counter walks neighbours j in AGGR and features k in MAC.
    for (int n = 0; n < N_NODES; n++)
      for (int j = 0; j < N_NODES; j++)
        if (i_q == NODE_W'(n) && cnt_q == CNT_W'(j)) adj_bit = adj_q[n*N_NODES+j];
    for (int k = 0; k < F_IN; k++)
      for (int j = 0; j < N_NODES; j++)
        if (cnt_q == CNT_W'(j)) x_sel[k] = x_q[(j*F_IN+k)*IN_W +: IN_W];
    for (int k = 0; k < F_IN; k++)
      if (cnt_q == CNT_W'(k)) begin
        agg_sel = aggr_q[k];
        for (int o = 0; o < F_OUT; o++) w_sel[o] = w_q[(k*F_OUT+o)*W_W +: W_W];
      end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_flat;
          adj_d   = adj;
          w_d     = w_flat;
          i_d     = '0;
          cnt_d   = '0;
          for (int k = 0; k < F_IN; k++) aggr_d[k] = '0;
          state_d = S_AGGR;
        end
      end
      S_AGGR: begin
        if (adj_bit)
          for (int k = 0; k < F_IN; k++) aggr_d[k] = aggr_q[k] + AG_W'(x_sel[k]);
        if (cnt_q == CNT_W'(N_NODES-1)) begin
          cnt_d   = '0;
          for (int o = 0; o < F_OUT; o++) acc_d[o] = '0;
          state_d = S_MAC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MAC: begin
        for (int o = 0; o < F_OUT; o++) begin
          prod[o]  = P_W'(agg_sel) * P_W'(w_sel[o]);
          acc_d[o] = acc_q[o] + ACC_W'(prod[o]);
        end
        if (cnt_q == CNT_W'(F_IN-1)) begin
          cnt_d   = '0;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (i_q == NODE_W'(N_NODES-1)) begin
            state_d = S_IDLE;
          end else begin
            i_d     = i_q + NODE_W'(1);
            cnt_d   = '0;
            for (int k = 0; k < F_IN; k++) aggr_d[k] = '0;
            state_d = S_AGGR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      adj_q   <= '0;
      w_q     <= '0;
      for (int k = 0; k < F_IN; k++) aggr_q[k] <= '0;
      for (int o = 0; o < F_OUT; o++) acc_q[o] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      adj_q   <= adj_d;
      w_q     <= w_d;
      aggr_q  <= aggr_d;
      acc_q   <= acc_d;
    end
  end

  // acc is frozen during EMIT, so the result stays stable while stalled.
  always_comb begin
    out_data = '0;
    for (int o = 0; o < F_OUT; o++)
      if (state_q == S_EMIT && !((RELU != 0) && acc_q[o][ACC_W-1]))
        out_data[o*ACC_W +: ACC_W] = acc_q[o];
  end

  assign out_valid = (state_q == S_EMIT);
  assign out_node  = i_q;
  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_gnn_aggr_layer.sv
// Bench for gnn_aggr_layer: default, RELU and 8-node instances checked against a
// plain-arithmetic model of the layer through an expected-value queue.
module tb_gnn_aggr_layer;
  localparam int AN = 4, AF = 4, AO = 2, AW = 21;
  localparam int BN = 8, BF = 3, BO = 4, BW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, sel_b, out_ready;
  logic a_in_valid, b_in_valid;
  assign a_in_valid = in_valid && !sel_b;
  assign b_in_valid = in_valid && sel_b;

  logic                 a_in_ready, a_out_valid, a_busy;
  logic [AN*AF*5-1:0]   a_x;
  logic [AN*AN-1:0]     a_adj;
  logic [AF*AO*5-1:0]   a_w;
  logic [1:0]           a_out_node, a_dbg;
  logic [AO*AW-1:0]     a_out_data;

  logic                 r_in_ready, r_out_valid, r_busy;
  logic [1:0]           r_out_node, r_dbg;
  logic [AO*AW-1:0]     r_out_data;

  logic                 b_in_ready, b_out_valid, b_busy;
  logic [BN*BF*5-1:0]   b_x;
  logic [BN*BN-1:0]     b_adj;
  logic [BF*BO*5-1:0]   b_w;
  logic [2:0]           b_out_node;
  logic [1:0]           b_dbg;
  logic [BO*BW-1:0]     b_out_data;

  gnn_aggr_layer dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x_flat(a_x), .adj(a_adj), .w_flat(a_w), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_node(a_out_node), .out_data(a_out_data),
    .busy(a_busy), .dbg_state(a_dbg));

  gnn_aggr_layer #(.RELU(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(r_in_ready),
    .x_flat(a_x), .adj(a_adj), .w_flat(a_w), .out_valid(r_out_valid),
    .out_ready(out_ready), .out_node(r_out_node), .out_data(r_out_data),
    .busy(r_busy), .dbg_state(r_dbg));

  gnn_aggr_layer #(.N_NODES(BN), .F_IN(BF), .F_OUT(BO), .ACC_W(BW)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x_flat(b_x), .adj(b_adj), .w_flat(b_w), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_node(b_out_node), .out_data(b_out_data),
    .busy(b_busy), .dbg_state(b_dbg));

  logic       cur_in_ready, cur_out_valid, cur_busy;
  logic [2:0] cur_node;
  assign cur_in_ready  = sel_b ? b_in_ready  : a_in_ready;
  assign cur_out_valid = sel_b ? b_out_valid : a_out_valid;
  assign cur_busy      = sel_b ? b_busy      : a_busy;
  assign cur_node      = sel_b ? b_out_node  : {1'b0, a_out_node};

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q[$];
  longint rexp_q[$];
  int     mx[8][4];
  int     mw[4][4];
  int     madj[8][8];
  int     nn, fi, fo;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: aggregated neighbour features times weights, summed per output.
  function automatic longint model_out(input int i, input int o, input bit relu);
    longint s = 0;
    for (int k = 0; k < fi; k++) begin
      longint agg = 0;
      for (int j = 0; j < nn; j++) if (madj[i][j] != 0) agg += mx[j][k];
      s += agg * mw[k][o];
    end
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  function automatic longint cur_data(input int o);
    longint v;
    if (sel_b) v = $signed(b_out_data[o*BW +: BW]);
    else       v = $signed(a_out_data[o*AW +: AW]);
    return v;
  endfunction

  function automatic longint r_data(input int o);
    longint v;
    v = $signed(r_out_data[o*AW +: AW]);
    return v;
  endfunction

  task automatic clear_model();
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) mx[n][k] = 0;
      for (int j = 0; j < 8; j++) madj[n][j] = 0;
    end
    for (int k = 0; k < 4; k++) for (int o = 0; o < 4; o++) mw[k][o] = 0;
  endtask

  task automatic random_model(input bit zero_row);
    for (int n = 0; n < nn; n++) begin
      for (int k = 0; k < fi; k++) mx[n][k] = int'($urandom_range(0, 31)) - 16;
      for (int j = 0; j < nn; j++) madj[n][j] = int'($urandom_range(0, 1));
    end
    for (int k = 0; k < fi; k++)
      for (int o = 0; o < fo; o++) mw[k][o] = int'($urandom_range(0, 31)) - 16;
    if (zero_row) for (int j = 0; j < nn; j++) madj[1][j] = 0;
  endtask

  task automatic load_job();
    for (int n = 0; n < nn; n++) begin
      for (int k = 0; k < fi; k++) begin
        if (sel_b) b_x[(n*BF+k)*5 +: 5] = 5'(mx[n][k]);
        else       a_x[(n*AF+k)*5 +: 5] = 5'(mx[n][k]);
      end
      for (int j = 0; j < nn; j++) begin
        if (sel_b) b_adj[n*BN+j] = (madj[n][j] != 0);
        else       a_adj[n*AN+j] = (madj[n][j] != 0);
      end
    end
    for (int k = 0; k < fi; k++)
      for (int o = 0; o < fo; o++) begin
        if (sel_b) b_w[(k*BO+o)*5 +: 5] = 5'(mw[k][o]);
        else       a_w[(k*AO+o)*5 +: 5] = 5'(mw[k][o]);
      end
    for (int i = 0; i < nn; i++)
      for (int o = 0; o < fo; o++) begin
        exp_q.push_back(model_out(i, o, 1'b0));
        if (!sel_b) rexp_q.push_back(model_out(i, o, 1'b1));
      end
  endtask

  task automatic accept();
    in_valid = 1'b1;
    check("in_ready_at_offer", cur_in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Collects nn results; t counts edges since accept, last marks the latest handshake edge.
  task automatic collect(input int stall_node);
    int     t = 0, last = 0, cnt = 0, stall_left = 0;
    bit     presented = 1'b0, hs_pending = 1'b0;
    longint snap_node = 0;
    longint snap_data[4];
    out_ready = 1'b1;
    while (cnt < nn && t < 600) begin
      @(posedge clk); #1;
      t++;
      if (hs_pending) last = t;
      if (cur_out_valid && !presented) begin
        presented = 1'b1;
        check("latency", t - last, nn + fi);
        check("out_node", cur_node, cnt);
        snap_node = cur_node;
        for (int o = 0; o < fo; o++) begin
          snap_data[o] = cur_data(o);
          check("out_data", snap_data[o], exp_q.pop_front());
        end
        if (!sel_b) begin
          check("relu_valid", r_out_valid, 1);
          check("relu_node", r_out_node, cnt);
          for (int o = 0; o < fo; o++) check("relu_data", r_data(o), rexp_q.pop_front());
        end
        if (cnt == stall_node) begin
          out_ready  = 1'b0;
          stall_left = 5;
        end
      end else if (presented && stall_left > 0) begin
        check("hold_valid", cur_out_valid, 1);
        check("hold_node", cur_node, snap_node);
        for (int o = 0; o < fo; o++) check("hold_data", cur_data(o), snap_data[o]);
        check("hold_busy", cur_busy, 1);
        check("hold_in_ready", cur_in_ready, 0);
        in_valid = stall_left[0];
        stall_left--;
        if (stall_left == 0) begin
          out_ready = 1'b1;
          in_valid  = 1'b0;
        end
      end
      hs_pending = cur_out_valid && out_ready;
      if (hs_pending) begin
        presented = 1'b0;
        cnt++;
      end
    end
    check("result_count", cnt, nn);
    @(posedge clk); #1;
    check("idle_in_ready", cur_in_ready, 1);
    check("idle_out_valid", cur_out_valid, 0);
    check("idle_busy", cur_busy, 0);
  endtask

  task automatic all_ones_job();
    clear_model();
    for (int n = 0; n < nn; n++) begin
      for (int k = 0; k < fi; k++) mx[n][k] = 1;
      for (int j = 0; j < nn; j++) madj[n][j] = 1;
    end
    for (int k = 0; k < fi; k++) for (int o = 0; o < fo; o++) mw[k][o] = 1;
    load_job();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel_b = 1'b0;
    a_x = '0; a_adj = '0; a_w = '0; b_x = '0; b_adj = '0; b_w = '0;
    nn = AN; fi = AF; fo = AO;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_a", a_in_ready, 0);
    check("rst_in_ready_b", b_in_ready, 0);
    check("rst_in_ready_r", r_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy | r_busy | b_busy, 0);
    check("rst_out_node", a_out_node, 0);
    check("rst_out_data", longint'(a_out_data), 0);
    check("rst_dbg", a_dbg | r_dbg | b_dbg, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);

    // All-ones graph: every output element is 16.
    all_ones_job();
    accept();
    collect(-1);

    // Identity adjacency with a single negative feature on node 2.
    clear_model();
    for (int n = 0; n < nn; n++) madj[n][n] = 1;
    mx[2][0] = -16;
    for (int o = 0; o < fo; o++) mw[0][o] = 15;
    check("identity_model", model_out(2, 0, 1'b0), -240);
    load_job();
    accept();
    collect(-1);

    // Backpressure at node 1 with in_valid pulsed during the stall.
    random_model(1'b0);
    load_job();
    accept();
    collect(1);

    for (int r = 0; r < 4; r++) begin
      random_model(r[0]);
      load_job();
      accept();
      collect(int'($urandom_range(0, 5)) - 1);
    end

    // Reset during MAC of node 1 aborts the job.
    all_ones_job();
    accept();
    out_ready = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", a_out_valid, 0);
    check("abort_busy", a_busy, 0);
    check("abort_in_ready", a_in_ready, 0);
    check("abort_out_data", longint'(a_out_data), 0);
    exp_q.delete();
    rexp_q.delete();
    rst = 1'b0;
    #1;
    check("abort_in_ready_after", a_in_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_result", a_out_valid, 0);
    end
    all_ones_job();
    accept();
    collect(-1);

    // Larger instance: 8 nodes, 3 input features, 4 outputs.
    sel_b = 1'b1;
    nn = BN; fi = BF; fo = BO;
    for (int r = 0; r < 3; r++) begin
      clear_model();
      random_model(r == 1);
      load_job();
      accept();
      collect(r == 2 ? 5 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
